// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the HDMI video pipeline.
// Holds the 720p60 defaults, the derived line/frame totals and the
// fixed widths of the pixel, line and frame counters.
package video_timing_pkg;

  // 720p60 timing (CEA-861, 74.25 MHz pixel clock)
  localparam int unsigned DEF_ACTIVE_H = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_ACTIVE_V = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;
  localparam int unsigned DEF_FPS      = 60;

  localparam int unsigned DEF_TOTAL_H = DEF_ACTIVE_H + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_TOTAL_V = DEF_ACTIVE_V + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Fixed output widths: TOTAL_H <= 2048, TOTAL_V <= 1024, FPS <= 64
  localparam int unsigned H_W  = 11;
  localparam int unsigned V_W  = 10;
  localparam int unsigned FC_W = 6;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter used for the pixel, line and frame counters.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears value to 0)
//   en         : advance by one on the next edge
//   wrap_c     : combinational, high when en is set and value is MODULUS-1
//   nxt_c      : combinational, value the counter takes on the next edge
//   value      : registered count, 0..MODULUS-1
module wrap_counter #(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned WIDTH   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             wrap_c,
  output logic [WIDTH-1:0] nxt_c,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Next value is exposed so the parent can register flags for it
  always_comb begin
    wrap_c = en && (value == LAST);
    nxt_c  = value;
    if (en) begin
      nxt_c = wrap_c ? '0 : value + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= nxt_c;
    end
  end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line coordinates, syncs, active-draw
// enable, new-frame pulse and frame counter for one video mode.
// Ports:
//   clk_in       : pixel clock
//   rst_in       : async active-low reset
//   h_count_out  : pixel index within the line
//   v_count_out  : line index within the frame
//   hs_out       : horizontal sync, active-high
//   vs_out       : vertical sync, active-high (whole lines)
//   ad_out       : active draw, pixel inside the visible area
//   nf_out       : one-cycle pulse at the first pixel after the last active one
//   fc_out       : frame counter, 0..FPS-1
// All flags are registered from the next position so they line up with the
// counts they describe.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H = DEF_ACTIVE_H,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned ACTIVE_V = DEF_ACTIVE_V,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned FPS      = DEF_FPS
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic [H_W-1:0]  h_count_out,
  output logic [V_W-1:0]  v_count_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ad_out,
  output logic            nf_out,
  output logic [FC_W-1:0] fc_out
);

  localparam int unsigned TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int unsigned TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_ACT      = H_W'(ACTIVE_H);
  localparam logic [H_W-1:0] HS_START   = H_W'(ACTIVE_H + H_FP);
  localparam logic [H_W-1:0] HS_END     = H_W'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_ACT      = V_W'(ACTIVE_V);
  localparam logic [V_W-1:0] V_LAST_ACT = V_W'(ACTIVE_V - 1);
  localparam logic [V_W-1:0] VS_START   = V_W'(ACTIVE_V + V_FP);
  localparam logic [V_W-1:0] VS_END     = V_W'(ACTIVE_V + V_FP + V_SYNC);

  logic           running;
  logic           h_wrap_c;
  logic           v_wrap_c;
  logic           fc_wrap_c;
  logic [H_W-1:0] h_nxt_c;
  logic [V_W-1:0] v_nxt_c;
  logic [FC_W-1:0] fc_nxt_c;
  logic           ad_nxt_c;
  logic           hs_nxt_c;
  logic           vs_nxt_c;
  logic           nf_nxt_c;
  logic           unused_wraps;

  // First edge out of reset only sets running, so (0,0) is held one cycle
  wrap_counter #(.MODULUS(TOTAL_H), .WIDTH(H_W)) u_h_cnt (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .en     (running),
    .wrap_c (h_wrap_c),
    .nxt_c  (h_nxt_c),
    .value  (h_count_out)
  );

  wrap_counter #(.MODULUS(TOTAL_V), .WIDTH(V_W)) u_v_cnt (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .en     (h_wrap_c),
    .wrap_c (v_wrap_c),
    .nxt_c  (v_nxt_c),
    .value  (v_count_out)
  );

  // Frame counter steps on the same edge that nf_out rises
  wrap_counter #(.MODULUS(FPS), .WIDTH(FC_W)) u_fc_cnt (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .en     (nf_nxt_c),
    .wrap_c (fc_wrap_c),
    .nxt_c  (fc_nxt_c),
    .value  (fc_out)
  );

  assign unused_wraps = ^{v_wrap_c, fc_wrap_c, fc_nxt_c};

  // Flags for the position the counters move to on this edge
  always_comb begin
    ad_nxt_c = (h_nxt_c < H_ACT) && (v_nxt_c < V_ACT);
    hs_nxt_c = (h_nxt_c >= HS_START) && (h_nxt_c < HS_END);
    vs_nxt_c = (v_nxt_c >= VS_START) && (v_nxt_c < VS_END);
    nf_nxt_c = (h_nxt_c == H_ACT) && (v_nxt_c == V_LAST_ACT);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      running <= 1'b0;
      ad_out  <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      nf_out  <= 1'b0;
    end else begin
      running <= 1'b1;
      ad_out  <= ad_nxt_c;
      hs_out  <= hs_nxt_c;
      vs_out  <= vs_nxt_c;
      nf_out  <= nf_nxt_c;
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench for video_sig_gen. One instance runs the 720p60 defaults for
// the line-level checks; a second, shrunk mode (16x10 total, 8x6 active)
// makes frame-level and frame-counter checks fit in a short run.
// Small mode: hs for h in [10,13), vs for v in [7,9), nf at (8,5), 160 cycles/frame.
module tb_video_sig_gen;

  logic clk;
  logic clk_en;
  logic rst_n;

  logic [10:0] hd_h;
  logic [9:0]  hd_v;
  logic        hd_hs, hd_vs, hd_ad, hd_nf;
  logic [5:0]  hd_fc;

  logic [10:0] sm_h;
  logic [9:0]  sm_v;
  logic        sm_hs, sm_vs, sm_ad, sm_nf;
  logic [5:0]  sm_fc;

  int n_checks;
  int n_fail;

  video_sig_gen dut_hd (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .h_count_out (hd_h),
    .v_count_out (hd_v),
    .hs_out      (hd_hs),
    .vs_out      (hd_vs),
    .ad_out      (hd_ad),
    .nf_out      (hd_nf),
    .fc_out      (hd_fc)
  );

  video_sig_gen #(
    .ACTIVE_H(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .ACTIVE_V(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FPS(60)
  ) dut_sm (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .h_count_out (sm_h),
    .v_count_out (sm_v),
    .hs_out      (sm_hs),
    .vs_out      (sm_vs),
    .ad_out      (sm_ad),
    .nf_out      (sm_nf),
    .fc_out      (sm_fc)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ad_fall, hs_first, hs_last, hs_cnt, ad_cnt, h_bad;
    int found, cyc;
    int ad_tot, ad_late, vs_in, vs_outside, hs_cyc, hs_pulse, nf_cnt, nf_h, nf_v;
    int last_h, last_v;
    logic prev_hs;
    int fc_bad, nf_pos_bad, fc_chg_bad, fc_max;
    logic [5:0] prev_fc;
    int hd_ad_cnt, hd_hs_cyc, hd_hs_pulse;
    logic prev_hd_hs;

    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b1;
    rst_n    = 1'b0;

    // Reset held with the clock running, then with it stopped
    repeat (5) step();
    check_eq("rst_run_hd", 32'({hd_h, hd_v, hd_hs, hd_vs, hd_ad, hd_nf, hd_fc}), 32'd0);
    check_eq("rst_run_sm", 32'({sm_h, sm_v, sm_hs, sm_vs, sm_ad, sm_nf, sm_fc}), 32'd0);
    @(negedge clk);
    clk_en = 1'b0;
    #50;
    check_eq("rst_stop_hd", 32'({hd_h, hd_v, hd_hs, hd_vs, hd_ad, hd_nf, hd_fc}), 32'd0);
    check_eq("rst_stop_sm", 32'({sm_h, sm_v, sm_hs, sm_vs, sm_ad, sm_nf, sm_fc}), 32'd0);
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release: pixel (0,0), visible
    step();
    check_eq("first_h", 32'(hd_h), 32'd0);
    check_eq("first_v", 32'(hd_v), 32'd0);
    check_eq("first_ad", 32'(hd_ad), 32'd1);
    check_eq("first_hs", 32'(hd_hs), 32'd0);
    check_eq("first_sm_ad", 32'(sm_ad), 32'd1);

    // Line 0 of the 720p instance
    ad_fall = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; ad_cnt = 1; h_bad = 0;
    for (int c = 1; c <= 1650; c++) begin
      step();
      if (c < 1650) begin
        if (int'(hd_h) != c || hd_v != 10'd0) h_bad++;
        if (hd_ad) ad_cnt++;
        else if (ad_fall < 0) ad_fall = int'(hd_h);
        if (hd_hs) begin
          if (hs_first < 0) hs_first = int'(hd_h);
          hs_last = int'(hd_h);
          hs_cnt++;
        end
      end
      if (c == 1649) check_eq("h_last_of_line", 32'(hd_h), 32'd1649);
    end
    check_eq("h_track_line0", 32'(h_bad), 32'd0);
    check_eq("ad_fall_h", 32'(ad_fall), 32'd1280);
    check_eq("ad_cnt_line0", 32'(ad_cnt), 32'd1280);
    check_eq("hs_first_h", 32'(hs_first), 32'd1390);
    check_eq("hs_last_h", 32'(hs_last), 32'd1429);
    check_eq("hs_cnt_line0", 32'(hs_cnt), 32'd40);
    check_eq("wrap_h", 32'(hd_h), 32'd0);
    check_eq("wrap_v", 32'(hd_v), 32'd1);
    check_eq("wrap_ad", 32'(hd_ad), 32'd1);

    // Small-mode full frame, starting from (0,0)
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sm_h == 11'd0 && sm_v == 10'd0) begin
        found = 1;
        break;
      end
    end
    check_eq("sm_align", 32'(found), 32'd1);
    cyc = 0; ad_tot = 0; ad_late = 0; vs_in = 0; vs_outside = 0; hs_cyc = 0; hs_pulse = 0;
    nf_cnt = 0; nf_h = -1; nf_v = -1; last_h = -1; last_v = -1; prev_hs = 1'b0;
    do begin
      if (sm_ad) ad_tot++;
      if (sm_ad && sm_v >= 10'd6) ad_late++;
      if (sm_vs && (sm_v == 10'd7 || sm_v == 10'd8)) vs_in++;
      if (sm_vs && !(sm_v == 10'd7 || sm_v == 10'd8)) vs_outside++;
      if (sm_hs) hs_cyc++;
      if (sm_hs && !prev_hs) hs_pulse++;
      if (sm_nf) begin
        nf_cnt++;
        nf_h = int'(sm_h);
        nf_v = int'(sm_v);
      end
      prev_hs = sm_hs;
      last_h  = int'(sm_h);
      last_v  = int'(sm_v);
      step();
      cyc++;
    end while (!(sm_h == 11'd0 && sm_v == 10'd0) && cyc < 400);
    check_eq("sm_frame_cycles", 32'(cyc), 32'd160);
    check_eq("sm_ad_cycles", 32'(ad_tot), 32'd48);
    check_eq("sm_ad_blank_lines", 32'(ad_late), 32'd0);
    check_eq("sm_vs_in_window", 32'(vs_in), 32'd32);
    check_eq("sm_vs_outside", 32'(vs_outside), 32'd0);
    check_eq("sm_hs_cycles", 32'(hs_cyc), 32'd30);
    check_eq("sm_hs_pulses", 32'(hs_pulse), 32'd10);
    check_eq("sm_nf_count", 32'(nf_cnt), 32'd1);
    check_eq("sm_nf_h", 32'(nf_h), 32'd8);
    check_eq("sm_nf_v", 32'(nf_v), 32'd5);
    check_eq("sm_last_h", 32'(last_h), 32'd15);
    check_eq("sm_last_v", 32'(last_v), 32'd9);

    // Asynchronous reset between edges, mid-frame
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sm_h == 11'd5 && sm_v == 10'd3) begin
        found = 1;
        break;
      end
    end
    check_eq("sm_find_mid", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_sm", 32'({sm_h, sm_v, sm_hs, sm_vs, sm_ad, sm_nf, sm_fc}), 32'd0);
    check_eq("mid_rst_hd", 32'({hd_h, hd_v, hd_hs, hd_vs, hd_ad, hd_nf, hd_fc}), 32'd0);
    repeat (3) step();
    check_eq("mid_rst_hold", 32'({sm_h, sm_ad, hd_h, hd_ad}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart, then 61 small-mode frames for the frame counter
    fc_bad = 0; nf_pos_bad = 0; fc_chg_bad = 0; fc_max = 0; nf_cnt = 0;
    hd_ad_cnt = 0; hd_hs_cyc = 0; hd_hs_pulse = 0; prev_hd_hs = 1'b0;
    for (int c = 0; c <= 9700; c++) begin
      prev_fc = sm_fc;
      step();
      if (c == 0) begin
        check_eq("restart_sm_h", 32'(sm_h), 32'd0);
        check_eq("restart_sm_v", 32'(sm_v), 32'd0);
        check_eq("restart_sm_ad", 32'(sm_ad), 32'd1);
        check_eq("restart_fc", 32'(sm_fc), 32'd0);
        check_eq("restart_hd_hv", 32'({hd_h, hd_v}), 32'd0);
      end else begin
        if (sm_nf) begin
          nf_cnt++;
          if (int'(sm_fc) != nf_cnt % 60) fc_bad++;
          if (sm_h != 11'd8 || sm_v != 10'd5) nf_pos_bad++;
        end else if (sm_fc != prev_fc) begin
          fc_chg_bad++;
        end
      end
      if (int'(sm_fc) > fc_max) fc_max = int'(sm_fc);
      if (hd_ad) hd_ad_cnt++;
      if (hd_hs) hd_hs_cyc++;
      if (hd_hs && !prev_hd_hs) hd_hs_pulse++;
      prev_hd_hs = hd_hs;
    end
    check_eq("fc_nf_count", 32'(nf_cnt), 32'd61);
    check_eq("fc_values", 32'(fc_bad), 32'd0);
    check_eq("nf_position", 32'(nf_pos_bad), 32'd0);
    check_eq("fc_off_nf_change", 32'(fc_chg_bad), 32'd0);
    check_eq("fc_max", 32'(fc_max), 32'd59);
    check_eq("fc_final", 32'(sm_fc), 32'd1);
    check_eq("hd_ad_6lines", 32'(hd_ad_cnt), 32'd7680);
    check_eq("hd_hs_cycles", 32'(hd_hs_cyc), 32'd240);
    check_eq("hd_hs_pulses", 32'(hd_hs_pulse), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
